// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute sequencer owning the RV32I program counter.
// Drives instruction-memory fetch requests and a one-cycle execute strobe.
// Selects the next PC from the sequential, branch/jump, halt and trap sources.
//
// Optional feature macro: PC_SEQ_MISALIGN_TRAP_EN
//   defined   -> a misaligned redirect vectors to TRAP_ADDR, pulses o_trap and
//                captures the offending target in o_bad_addr.
//   undefined -> branch_target[1:0] is forced to 0; o_trap/o_bad_addr tie to 0.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   o_imem_req/o_imem_addr fetch request and address (addr == pc)
//   i_imem_ready          instruction available (FETCH only)
//   o_instr_valid         execute strobe (EXEC)
//   o_pc                  program counter
//   i_branch_taken/i_branch_target  redirect (EXEC only)
//   i_stall               datapath hold (EXEC only)
//   i_halt_req            halt request (EXEC only); i_resume leaves HALT
//   o_halted              high in HALT
//   o_trap, o_bad_addr    misaligned-redirect trap pulse and captured address
//   o_instret             retired-instruction counter
`timescale 1ns/1ps
module pc_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
`ifdef PC_SEQ_MISALIGN_TRAP_EN
 ,parameter logic [31:0] TRAP_ADDR  = 32'h0000_0100
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_stall,
  input  logic        i_halt_req,
  input  logic        i_resume,
  output logic        o_halted,
  output logic        o_trap,
  output logic [31:0] o_bad_addr,
  output logic [31:0] o_instret
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_instret;
  logic        w_misalign, w_retire;
  logic [31:0] w_target;

  // Redirect targets are word-aligned in both builds; in the trap build a
  // misaligned target never reaches this path.
  assign w_target = i_branch_taken ? (i_branch_target & ~32'h3) : (r_pc + 32'd4);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign w_misalign = i_branch_taken && (i_branch_target[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // A stalled or trapped instruction does not retire.
  assign w_retire = (r_state == S_EXEC) && !i_stall && !w_misalign;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_FETCH;
      S_FETCH: if (i_imem_ready) w_next = S_EXEC;
      S_EXEC: begin
        if (!i_stall) begin
          if (w_misalign)      w_next = S_FETCH;  // trap overrides halt
          else if (i_halt_req) w_next = S_HALT;
          else                 w_next = S_FETCH;
        end
      end
      S_HALT:  if (i_resume) w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_imem_req    = (r_state == S_FETCH);
    o_instr_valid = (r_state == S_EXEC);
    o_halted      = (r_state == S_HALT);
  end

  assign o_pc        = r_pc;
  assign o_imem_addr = r_pc;
  assign o_instret   = r_instret;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic        r_trap;
  logic [31:0] r_bad_addr;
  logic        w_take_trap;

  assign w_take_trap = (r_state == S_EXEC) && !i_stall && w_misalign;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_ADDR;
      r_instret  <= 32'd0;
      r_trap     <= 1'b0;
      r_bad_addr <= 32'd0;
    end else begin
      r_trap <= w_take_trap;  // high only for the first FETCH after the trap
      if (w_take_trap) begin
        r_pc       <= TRAP_ADDR;
        r_bad_addr <= i_branch_target;
      end else if (w_retire) begin
        r_pc      <= w_target;
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign o_trap     = r_trap;
  assign o_bad_addr = r_bad_addr;
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc      <= RESET_ADDR;
      r_instret <= 32'd0;
    end else if (w_retire) begin
      r_pc      <= w_target;
      r_instret <= r_instret + 32'd1;
    end
  end

  assign o_trap     = 1'b0;
  assign o_bad_addr = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, instr_valid, halted, trap;
  logic [31:0] imem_addr, pc, bad_addr, instret, branch_target;
  logic        branch_taken, stall, halt_req, resume;
  int          vectors = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ready(imem_ready),
    .o_instr_valid(instr_valid), .o_pc(pc),
    .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .i_stall(stall), .i_halt_req(halt_req), .i_resume(resume),
    .o_halted(halted), .o_trap(trap), .o_bad_addr(bad_addr), .o_instret(instret)
  );

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
    stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
    #12;
    vectors++; if (pc !== 32'h0)       begin errs++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    vectors++; if (imem_req !== 1'b0)  begin errs++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    vectors++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL reset_iv got=%b exp=0", instr_valid); end
    vectors++; if (halted !== 1'b0 || trap !== 1'b0) begin errs++; $display("FAIL reset_flags halted=%b trap=%b exp=0/0", halted, trap); end
    vectors++; if (bad_addr !== 32'h0 || instret !== 32'h0) begin errs++; $display("FAIL reset_regs bad=%h instret=%h exp=0/0", bad_addr, instret); end
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++; if (imem_req !== 1'b0) begin errs++; $display("FAIL idle_req got=%b exp=0", imem_req); end
  endtask

  // pc 0 -> 4 -> 8 at one update per two cycles
  task automatic test_sequential();
    tick();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL first_fetch req=%b addr=%h exp=1/0", imem_req, imem_addr); end
    tick();
    vectors++; if (instr_valid !== 1'b1 || pc !== 32'h0) begin errs++; $display("FAIL exec0 iv=%b pc=%h exp=1/0", instr_valid, pc); end
    tick();
    vectors++; if (pc !== 32'h4 || instret !== 32'd1 || imem_req !== 1'b1) begin errs++; $display("FAIL seq4 pc=%h instret=%0d req=%b exp=4/1/1", pc, instret, imem_req); end
    tick(); tick();
    vectors++; if (pc !== 32'h8 || instret !== 32'd2) begin errs++; $display("FAIL seq8 pc=%h instret=%0d exp=8/2", pc, instret); end
  endtask

  // imem_ready low for 3 FETCH cycles at pc=0x8
  task automatic test_fetch_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin errs++; $display("FAIL fetch_wait%0d req=%b addr=%h iv=%b exp=1/8/0", i, imem_req, imem_addr, instr_valid); end
    end
    imem_ready = 1'b1;
    tick();
    vectors++; if (instr_valid !== 1'b1 || pc !== 32'h8) begin errs++; $display("FAIL wait_exec iv=%b pc=%h exp=1/8", instr_valid, pc); end
    tick();
    vectors++; if (pc !== 32'hC || instret !== 32'd3) begin errs++; $display("FAIL after_wait pc=%h instret=%0d exp=c/3", pc, instret); end
    tick(); tick(); tick();  // EXEC C, FETCH 10, EXEC 10
    vectors++; if (instr_valid !== 1'b1 || pc !== 32'h10) begin errs++; $display("FAIL exec10 iv=%b pc=%h exp=1/10", instr_valid, pc); end
  endtask

  // Branch held behind two stall cycles
  task automatic test_stall_branch();
    branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (pc !== 32'h10 || instr_valid !== 1'b1 || instret !== 32'd4) begin errs++; $display("FAIL stall%0d pc=%h iv=%b instret=%0d exp=10/1/4", i, pc, instr_valid, instret); end
    end
    stall = 1'b0;
    tick();
    vectors++; if (pc !== 32'h40 || instret !== 32'd5 || imem_req !== 1'b1) begin errs++; $display("FAIL branch40 pc=%h instret=%0d req=%b exp=40/5/1", pc, instret, imem_req); end
    branch_taken = 1'b0;
  endtask

  // Asynchronous reset while stalled in EXEC
  task automatic test_reset_mid_stall();
    tick();
    stall = 1'b1;
    tick();
    vectors++; if (pc !== 32'h40 || instr_valid !== 1'b1 || instret !== 32'd5) begin errs++; $display("FAIL pre_rst pc=%h iv=%b instret=%0d exp=40/1/5", pc, instr_valid, instret); end
    #2; rst_n = 1'b0; #1;
    vectors++; if (pc !== 32'h0 || instret !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin errs++; $display("FAIL async_rst pc=%h instret=%0d iv=%b req=%b exp=0/0/0/0", pc, instret, instr_valid, imem_req); end
    stall = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Jump to 0x20, halt there, then resume
  task automatic test_halt();
    tick(); tick();  // FETCH 0, EXEC 0
    branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    branch_taken = 1'b0;
    vectors++; if (pc !== 32'h20 || instret !== 32'd1) begin errs++; $display("FAIL jump20 pc=%h instret=%0d exp=20/1", pc, instret); end
    tick();
    halt_req = 1'b1;
    tick();
    vectors++; if (halted !== 1'b1 || pc !== 32'h24 || imem_req !== 1'b0 || instret !== 32'd2) begin errs++; $display("FAIL halt halted=%b pc=%h req=%b instret=%0d exp=1/24/0/2", halted, pc, imem_req, instret); end
    tick();  // halt_req still high: ignored in HALT
    halt_req = 1'b0;
    vectors++; if (halted !== 1'b1 || pc !== 32'h24) begin errs++; $display("FAIL halt_hold halted=%b pc=%h exp=1/24", halted, pc); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    vectors++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h24) begin errs++; $display("FAIL resume halted=%b req=%b addr=%h exp=0/1/24", halted, imem_req, imem_addr); end
    tick();  // EXEC at 0x24
  endtask

  // Misaligned redirect, then pc wrap at 0xFFFF_FFFC
  task automatic test_misalign_wrap();
    logic [31:0] exp_pc, exp_bad, exp_ir;
    logic        exp_trap;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    exp_pc = 32'h100; exp_bad = 32'h42; exp_ir = 32'd2; exp_trap = 1'b1;
`else
    exp_pc = 32'h40;  exp_bad = 32'h0;  exp_ir = 32'd3; exp_trap = 1'b0;
`endif
    branch_taken = 1'b1; branch_target = 32'h42; halt_req = 1'b1;
    tick();
    branch_taken = 1'b0; halt_req = 1'b0;
`ifndef PC_SEQ_MISALIGN_TRAP_EN
    // without trap logic the halt request is honoured
    vectors++; if (halted !== 1'b1) begin errs++; $display("FAIL notrap_halt halted=%b exp=1", halted); end
    resume = 1'b1; tick(); resume = 1'b0;
`endif
    vectors++; if (pc !== exp_pc || bad_addr !== exp_bad || instret !== exp_ir || trap !== exp_trap || imem_req !== 1'b1) begin errs++; $display("FAIL misalign pc=%h bad=%h instret=%0d trap=%b req=%b exp=%h/%h/%0d/%b/1", pc, bad_addr, instret, trap, imem_req, exp_pc, exp_bad, exp_ir, exp_trap); end
    tick();
    vectors++; if (trap !== 1'b0 || instr_valid !== 1'b1) begin errs++; $display("FAIL trap_pulse trap=%b iv=%b exp=0/1", trap, instr_valid); end
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    vectors++; if (pc !== 32'hFFFF_FFFC || instret !== exp_ir + 32'd1) begin errs++; $display("FAIL to_top pc=%h instret=%0d exp=fffffffc/%0d", pc, instret, exp_ir + 32'd1); end
    tick(); tick();
    vectors++; if (pc !== 32'h0 || instret !== exp_ir + 32'd2) begin errs++; $display("FAIL wrap pc=%h instret=%0d exp=0/%0d", pc, instret, exp_ir + 32'd2); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fetch_wait();
    test_stall_branch();
    test_reset_mid_stall();
    test_halt();
    test_misalign_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
